// File: rtl/branches_pkg.sv
// Branch comparison encodings shared by the ALU and its users.
package branches_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_op_e;

endpackage

// File: rtl/lx32_pkg.sv
// Core-wide ALU encodings and the request/response bundles for a shared ALU.
package lx32_pkg;
  import branches_pkg::*;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    alu_op_e         alu_control;
    logic            is_branch;
    branch_op_e      branch_op;
  } alu_req_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            branch_true;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU with a branch-condition evaluator.
module alu
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  alu_op_e          alu_control,
  input  logic             is_branch,
  input  branch_op_e       branch_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_branch_true
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;
  logic          cond;

  assign shamt = src_b[SW-1:0];

  // Arithmetic/logic result selection.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
      default:  alu_result = '0;
    endcase
  end

  // Branch comparison; only reported when a branch is being evaluated.
  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_EQ:   cond = (src_a == src_b);
      BR_NE:   cond = (src_a != src_b);
      BR_LT:   cond = ($signed(src_a) < $signed(src_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond = (src_a < src_b);
      BR_GEU:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign alu_branch_true = is_branch & cond;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first eligible index after last_grant, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         eligible,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant
);

  int   idx;
  logic found;

  // Scan last_grant+1 .. last_grant+NREQ modulo NREQ; at most one bit set.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters; each owns a one-entry response slot.
module alu_arbiter
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_src_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_src_b,
  input  alu_op_e [NREQ-1:0]          req_alu_control,
  input  logic [NREQ-1:0]             req_is_branch,
  input  branch_op_e [NREQ-1:0]       req_branch_op,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [NREQ-1:0][WIDTH-1:0]  rsp_result,
  output logic [NREQ-1:0]             rsp_branch_true
);

  localparam int             IW       = $clog2(NREQ);
  localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);

  logic [NREQ-1:0]            slot_free;
  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            grant;
  logic [IW-1:0]              grant_idx;

  logic [WIDTH-1:0]           alu_src_a;
  logic [WIDTH-1:0]           alu_src_b;
  alu_op_e                    alu_op;
  logic                       alu_is_branch;
  branch_op_e                 alu_branch_op;
  logic [WIDTH-1:0]           alu_result;
  logic                       alu_branch_true;

  logic [NREQ-1:0]            rsp_valid_d,       rsp_valid_q;
  logic [NREQ-1:0][WIDTH-1:0] rsp_result_d,      rsp_result_q;
  logic [NREQ-1:0]            rsp_branch_true_d, rsp_branch_true_q;
  logic [IW-1:0]              last_grant_d,      last_grant_q;

  // A slot can take a new result if empty or being drained this cycle; no grants in reset.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign eligible  = req_valid & slot_free & {NREQ{~rst}};

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req_ready = grant;

  // Steer the granted requester onto the ALU; idle drives a harmless ADD of zeros.
  always_comb begin
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_op        = ALU_ADD;
    alu_is_branch = 1'b0;
    alu_branch_op = BR_EQ;
    grant_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_src_a     = req_src_a[i];
        alu_src_b     = req_src_b[i];
        alu_op        = req_alu_control[i];
        alu_is_branch = req_is_branch[i];
        alu_branch_op = req_branch_op[i];
        grant_idx     = IW'(i);
      end
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .src_a           (alu_src_a),
    .src_b           (alu_src_b),
    .alu_control     (alu_op),
    .is_branch       (alu_is_branch),
    .branch_op       (alu_branch_op),
    .alu_result      (alu_result),
    .alu_branch_true (alu_branch_true)
  );

  // Slot refill on grant, drain on consume; data holds when the slot empties.
  always_comb begin
    rsp_valid_d       = rsp_valid_q;
    rsp_result_d      = rsp_result_q;
    rsp_branch_true_d = rsp_branch_true_q;
    last_grant_d      = (|grant) ? grant_idx : last_grant_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]       = 1'b1;
        rsp_result_d[i]      = alu_result;
        rsp_branch_true_d[i] = alu_branch_true;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // Slot and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q       <= '0;
      rsp_result_q      <= '0;
      rsp_branch_true_q <= '0;
      last_grant_q      <= LAST_RST;
    end else begin
      rsp_valid_q       <= rsp_valid_d;
      rsp_result_q      <= rsp_result_d;
      rsp_branch_true_q <= rsp_branch_true_d;
      last_grant_q      <= last_grant_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_branch_true = rsp_branch_true_q;

endmodule
